// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave register bank.
// REG_NUM read/write control registers followed by STAT_NUM read-only status
// registers in word-index space. Unmapped indices answer DECERR, writes to
// status registers answer SLVERR. Write-commit and status-read pulses are
// exported so user logic can react to register traffic (e.g. clear-on-read).
module axil_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16,
    parameter int STAT_NUM   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                     s_awprot,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    output logic [1:0]                     s_bresp,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                     s_arprot,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic [REG_NUM*DATA_WIDTH-1:0]  ctrl_reg,
    output logic [REG_NUM-1:0]             ctrl_wr_pulse,
    input  logic [STAT_NUM*DATA_WIDTH-1:0] stat_in,
    output logic [STAT_NUM-1:0]            stat_rd_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word index of a byte address; byte-offset bits are dropped.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:ADDR_LSB];
    endfunction

    // One-hot select of the control register addressed (all zero if not RW).
    function automatic logic [REG_NUM-1:0] rw_onehot(input logic [ADDR_WIDTH-1:0] a);
        logic [REG_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            oh[i] = (addr_idx(a) == IDX_W'(i));
        end
        return oh;
    endfunction

    // One-hot select of the status register addressed (all zero if not RO).
    function automatic logic [STAT_NUM-1:0] ro_onehot(input logic [ADDR_WIDTH-1:0] a);
        logic [STAT_NUM-1:0] oh;
        oh = '0;
        for (int j = 0; j < STAT_NUM; j++) begin
            oh[j] = (addr_idx(a) == IDX_W'(REG_NUM + j));
        end
        return oh;
    endfunction

    // Write-path state
    logic                  aw_hold_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic                  w_hold_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [STRB_W-1:0]     w_strb_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic [REG_NUM-1:0]    ctrl_wr_pulse_r;
    logic [DATA_WIDTH-1:0] ctrl_r [REG_NUM];

    // Read-path state
    logic                  rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic [STAT_NUM-1:0]   stat_rd_pulse_r;

    // Write-path combinational helpers
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic [REG_NUM-1:0]    commit_oh_s;
    logic                  commit_ro_s;
    logic                  aw_hold_nx_s;
    logic                  w_hold_nx_s;
    logic                  bvalid_nx_s;
    logic [ADDR_WIDTH-1:0] aw_addr_nx_s;
    logic [REG_NUM-1:0]    wr_pulse_nx_s;

    // Read-path combinational helpers
    logic                  ar_hs_s;
    logic [REG_NUM-1:0]    rd_rw_oh_s;
    logic [STAT_NUM-1:0]   rd_ro_oh_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [1:0]            rd_resp_s;

    // Protection bits and byte offsets carry no meaning for this block.
    logic unused_s;
    assign unused_s = ^{s_awprot, s_arprot, s_awaddr[ADDR_LSB-1:0],
                        s_araddr[ADDR_LSB-1:0], aw_addr_r[ADDR_LSB-1:0]};

    assign aw_hs_s     = s_awvalid && !aw_hold_r && !bvalid_r;
    assign w_hs_s      = s_wvalid  && !w_hold_r  && !bvalid_r;
    assign commit_s    = aw_hold_r && w_hold_r && !bvalid_r;
    assign commit_oh_s = rw_onehot(aw_addr_r);
    assign commit_ro_s = |ro_onehot(aw_addr_r);
    assign aw_addr_nx_s = aw_hs_s ? s_awaddr : aw_addr_r;

    // Next-state of holds/bvalid, used to register the commit pulse so it is
    // high exactly during the commit cycle rather than one cycle late.
    always_comb begin
        if (commit_s) begin
            aw_hold_nx_s = 1'b0;
        end else if (aw_hs_s) begin
            aw_hold_nx_s = 1'b1;
        end else begin
            aw_hold_nx_s = aw_hold_r;
        end

        if (commit_s) begin
            w_hold_nx_s = 1'b0;
        end else if (w_hs_s) begin
            w_hold_nx_s = 1'b1;
        end else begin
            w_hold_nx_s = w_hold_r;
        end

        if (commit_s) begin
            bvalid_nx_s = 1'b1;
        end else if (bvalid_r && s_bready) begin
            bvalid_nx_s = 1'b0;
        end else begin
            bvalid_nx_s = bvalid_r;
        end

        if (aw_hold_nx_s && w_hold_nx_s && !bvalid_nx_s) begin
            wr_pulse_nx_s = rw_onehot(aw_addr_nx_s);
        end else begin
            wr_pulse_nx_s = '0;
        end
    end

    // AW/W holding registers, write response and commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_hold_r       <= 1'b0;
            aw_addr_r       <= '0;
            w_hold_r        <= 1'b0;
            w_data_r        <= '0;
            w_strb_r        <= '0;
            bvalid_r        <= 1'b0;
            bresp_r         <= RESP_OKAY;
            ctrl_wr_pulse_r <= '0;
        end else begin
            aw_hold_r       <= aw_hold_nx_s;
            w_hold_r        <= w_hold_nx_s;
            bvalid_r        <= bvalid_nx_s;
            ctrl_wr_pulse_r <= wr_pulse_nx_s;
            if (aw_hs_s) begin
                aw_addr_r <= s_awaddr;
            end
            if (w_hs_s) begin
                w_data_r <= s_wdata;
                w_strb_r <= s_wstrb;
            end
            if (commit_s) begin
                if (|commit_oh_s) begin
                    bresp_r <= RESP_OKAY;
                end else if (commit_ro_s) begin
                    bresp_r <= RESP_SLVERR;
                end else begin
                    bresp_r <= RESP_DECERR;
                end
            end
        end
    end

    // Control registers: byte-wise update on commit to an RW index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                ctrl_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (commit_s && commit_oh_s[i] && w_strb_r[b]) begin
                        ctrl_r[i][b*8 +: 8] <= w_data_r[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign ar_hs_s    = s_arvalid && !rvalid_r;
    assign rd_rw_oh_s = rw_onehot(s_araddr);
    assign rd_ro_oh_s = ro_onehot(s_araddr);

    // Read data mux: AND-OR over one-hot selects, zero when unmapped.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{rd_rw_oh_s[i]}} & ctrl_r[i]);
        end
        for (int j = 0; j < STAT_NUM; j++) begin
            rd_data_s = rd_data_s |
                        ({DATA_WIDTH{rd_ro_oh_s[j]}} & stat_in[j*DATA_WIDTH +: DATA_WIDTH]);
        end
        if ((|rd_rw_oh_s) || (|rd_ro_oh_s)) begin
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_resp_s = RESP_DECERR;
        end
    end

    // Read response register; data held stable until the R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r        <= 1'b0;
            rdata_r         <= '0;
            rresp_r         <= RESP_OKAY;
            stat_rd_pulse_r <= '0;
        end else begin
            if (ar_hs_s) begin
                rvalid_r        <= 1'b1;
                rdata_r         <= rd_data_s;
                rresp_r         <= rd_resp_s;
                stat_rd_pulse_r <= rd_ro_oh_s;
            end else begin
                stat_rd_pulse_r <= '0;
                if (rvalid_r && s_rready) begin
                    rvalid_r <= 1'b0;
                end
            end
        end
    end

    assign s_awready     = !aw_hold_r && !bvalid_r;
    assign s_wready      = !w_hold_r && !bvalid_r;
    assign s_bvalid      = bvalid_r;
    assign s_bresp       = bresp_r;
    assign s_arready     = !rvalid_r;
    assign s_rvalid      = rvalid_r;
    assign s_rdata       = rdata_r;
    assign s_rresp       = rresp_r;
    assign ctrl_wr_pulse = ctrl_wr_pulse_r;
    assign stat_rd_pulse = stat_rd_pulse_r;

    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_ctrl_flat
        assign ctrl_reg[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_r[gi];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level model of the register bank.
module tb_axil_reg_slave;

    localparam int RN = 16;
    localparam int SN = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_awvalid, s_awready;
    logic [31:0]  s_awaddr;
    logic [2:0]   s_awprot;
    logic         s_wvalid, s_wready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_bvalid, s_bready;
    logic [1:0]   s_bresp;
    logic         s_arvalid, s_arready;
    logic [31:0]  s_araddr;
    logic [2:0]   s_arprot;
    logic         s_rvalid, s_rready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic [511:0] ctrl_reg;
    logic [15:0]  ctrl_wr_pulse;
    logic [255:0] stat_in;
    logic [7:0]   stat_rd_pulse;

    int checks   = 0;
    int failures = 0;

    // Model state: register contents plus outstanding-transaction bookkeeping.
    logic [511:0] m_ctrl;
    bit           m_aw_full, m_w_full, m_bvalid, m_rvalid;
    logic [31:0]  m_aw_addr, m_w_data, m_rdata;
    logic [3:0]   m_w_strb;
    logic [1:0]   m_bresp, m_rresp;
    logic [15:0]  m_wr_pulse;
    logic [7:0]   m_rd_pulse;

    axil_reg_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(RN), .STAT_NUM(SN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .ctrl_reg(ctrl_reg), .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_in(stat_in), .stat_rd_pulse(stat_rd_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_aw_full = 0; m_w_full = 0; m_bvalid = 0; m_rvalid = 0;
        m_aw_addr = '0; m_w_data = '0; m_w_strb = '0; m_rdata = '0;
        m_bresp = 2'd0; m_rresp = 2'd0; m_wr_pulse = '0; m_rd_pulse = '0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int widx, ridx;
        bit aw_rdy, w_rdy, commit;
        logic [511:0] old_ctrl;
        old_ctrl = m_ctrl;
        aw_rdy = !m_aw_full && !m_bvalid;
        w_rdy  = !m_w_full && !m_bvalid;
        commit = m_aw_full && m_w_full && !m_bvalid;

        if (s_arvalid && !m_rvalid) begin
            ridx = int'(s_araddr >> 2);
            m_rvalid = 1; m_rd_pulse = '0;
            if (ridx < RN) begin
                m_rdata = old_ctrl[ridx*32 +: 32]; m_rresp = 2'd0;
            end else if (ridx < RN + SN) begin
                m_rdata = stat_in[(ridx-RN)*32 +: 32]; m_rresp = 2'd0;
                m_rd_pulse[ridx-RN] = 1'b1;
            end else begin
                m_rdata = 32'd0; m_rresp = 2'd3;
            end
        end else begin
            m_rd_pulse = '0;
            if (m_rvalid && s_rready) m_rvalid = 0;
        end

        if (commit) begin
            widx = int'(m_aw_addr >> 2);
            if (widx < RN) begin
                for (int b = 0; b < 4; b++)
                    if (m_w_strb[b]) m_ctrl[widx*32 + b*8 +: 8] = m_w_data[b*8 +: 8];
                m_bresp = 2'd0;
            end else if (widx < RN + SN) begin
                m_bresp = 2'd2;
            end else begin
                m_bresp = 2'd3;
            end
            m_bvalid = 1; m_aw_full = 0; m_w_full = 0;
        end else if (m_bvalid && s_bready) begin
            m_bvalid = 0;
        end
        if (s_awvalid && aw_rdy) begin m_aw_full = 1; m_aw_addr = s_awaddr; end
        if (s_wvalid && w_rdy) begin m_w_full = 1; m_w_data = s_wdata; m_w_strb = s_wstrb; end

        m_wr_pulse = '0;
        if (m_aw_full && m_w_full && !m_bvalid) begin
            widx = int'(m_aw_addr >> 2);
            if (widx < RN) m_wr_pulse[widx] = 1'b1;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        check("awready", s_awready, !m_aw_full && !m_bvalid);
        check("wready", s_wready, !m_w_full && !m_bvalid);
        check("arready", s_arready, !m_rvalid);
        check("bvalid", s_bvalid, m_bvalid);
        check("rvalid", s_rvalid, m_rvalid);
        if (m_bvalid) check("bresp", s_bresp, m_bresp);
        if (m_rvalid) begin
            check("rdata", s_rdata, m_rdata);
            check("rresp", s_rresp, m_rresp);
        end
        check("ctrl_reg", ctrl_reg, m_ctrl);
        check("ctrl_wr_pulse", ctrl_wr_pulse, m_wr_pulse);
        check("stat_rd_pulse", stat_rd_pulse, m_rd_pulse);
    end

    // One clock edge; returns 1ns after it with the model advanced.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge();
    endtask

    task automatic idle();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    endtask

    task automatic async_reset();
        idle();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("rst_bvalid", s_bvalid, 1'b0);
        check("rst_rvalid", s_rvalid, 1'b0);
        check("rst_ctrl", ctrl_reg, 512'd0);
        step();
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_addr();
        int idx;
        idx = int'($urandom_range(0, 27));
        return 32'(idx * 4) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; idle();
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_awprot = 3'd0; s_arprot = 3'd0; s_bready = 1; s_rready = 1; stat_in = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1;
        check("reset_ctrl", ctrl_reg, 512'd0);
        check("reset_awready", s_awready, 1'b1);
        check("reset_rdata", s_rdata, 32'd0);

        // Same-cycle AW+W to idx 2
        s_awvalid = 1; s_awaddr = 32'h08; s_wvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        step(); idle();
        check("t1_pulse_commit", ctrl_wr_pulse, 16'h0004);
        check("t1_bvalid_early", s_bvalid, 1'b0);
        step();
        check("t1_bvalid", s_bvalid, 1'b1);
        check("t1_bresp", s_bresp, 2'b00);
        check("t1_ctrl2", ctrl_reg[64 +: 32], 32'hDEADBEEF);
        check("t1_pulse_gone", ctrl_wr_pulse, 16'h0000);
        step();

        // W two cycles before AW, byte 0 only, response held off 5 cycles
        s_bready = 0;
        s_wvalid = 1; s_wdata = 32'h000000AA; s_wstrb = 4'h1;
        step(); idle(); step(); step();
        s_awvalid = 1; s_awaddr = 32'h08;
        step(); idle(); step();
        for (int i = 0; i < 5; i++) begin
            check("t2_awready", s_awready, 1'b0);
            check("t2_wready", s_wready, 1'b0);
            check("t2_bvalid", s_bvalid, 1'b1);
            step();
        end
        s_bready = 1;
        step();
        check("t2_bvalid_low", s_bvalid, 1'b0);
        check("t2_ctrl2", ctrl_reg[64 +: 32], 32'hDEADBEAA);

        // Write to RO idx 16, then read it
        s_awvalid = 1; s_awaddr = 32'h40; s_wvalid = 1; s_wdata = 32'h1; s_wstrb = 4'hF;
        step(); idle(); step();
        check("t3_bresp", s_bresp, 2'b10);
        stat_in[31:0] = 32'h12345678;
        s_rready = 0; s_arvalid = 1; s_araddr = 32'h40;
        step(); idle();
        check("t3_rdata", s_rdata, 32'h12345678);
        check("t3_rresp", s_rresp, 2'b00);
        check("t3_stat_pulse", stat_rd_pulse, 8'h01);
        step();
        check("t3_stat_pulse_gone", stat_rd_pulse, 8'h00);
        s_rready = 1; step();

        // Unmapped read and write at idx 32
        s_arvalid = 1; s_araddr = 32'h80;
        step(); idle();
        check("t4_rdata", s_rdata, 32'd0);
        check("t4_rresp", s_rresp, 2'b11);
        s_awvalid = 1; s_awaddr = 32'h80; s_wvalid = 1;
        step(); idle(); step();
        check("t4_bresp", s_bresp, 2'b11);
        step();

        // Stalled read of idx 2 while stat_in and ctrl change
        s_rready = 0; s_arvalid = 1; s_araddr = 32'h08;
        step();
        s_awvalid = 1; s_awaddr = 32'h08; s_wvalid = 1; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            stat_in = {8{$urandom}};
            check("t5_rdata_stable", s_rdata, 32'hDEADBEAA);
            check("t5_arready", s_arready, 1'b0);
            step();
            s_awvalid = 0; s_wvalid = 0;
        end
        s_rready = 1; step(); step(); idle(); step();

        // Async reset with bvalid and rvalid pending, then fresh write
        s_bready = 0; s_rready = 0;
        s_awvalid = 1; s_awaddr = 32'h0C; s_wvalid = 1; s_wdata = 32'h55; s_wstrb = 4'hF;
        s_arvalid = 1; s_araddr = 32'h0C;
        step(); idle(); step();
        async_reset();
        s_bready = 1; s_rready = 1;
        // AW held when reset hits; a later lone W must not complete it
        s_awvalid = 1; s_awaddr = 32'h14;
        step(); idle();
        async_reset();
        s_wvalid = 1; s_wdata = 32'hCAFE0001; s_wstrb = 4'hF;
        step(); idle(); step(); step();
        check("t6_no_stale_commit", s_bvalid, 1'b0);
        s_awvalid = 1; s_awaddr = 32'h14;
        step(); idle(); step();
        check("t6_fresh_bresp", s_bresp, 2'b00);
        check("t6_fresh_ctrl5", ctrl_reg[160 +: 32], 32'hCAFE0001);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_awvalid = ($urandom_range(0, 2) == 0);
            s_awaddr  = rand_addr();
            s_wvalid  = ($urandom_range(0, 2) == 0);
            s_wdata   = $urandom;
            s_wstrb   = 4'($urandom_range(0, 15));
            s_bready  = ($urandom_range(0, 3) != 0);
            s_arvalid = ($urandom_range(0, 1) == 0);
            s_araddr  = rand_addr();
            s_rready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) stat_in = {8{$urandom}};
            step();
        end
        idle(); s_bready = 1; s_rready = 1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
